// File: rtl/mru_pkg.sv
// mru_pkg -- shared definitions for the MRU request scheduler.
// Holds the opcode encodings, the idle opcode, the per-opcode latency table
// and the scheduler FSM state enum.
package mru_pkg;

    localparam logic [2:0] OP_RADIX3 = 3'b000;
    localparam logic [2:0] OP_RADIX4 = 3'b001;
    localparam logic [2:0] OP_RADIX6 = 3'b010;
    localparam logic [2:0] OP_FFT    = 3'b011;
    localparam logic [2:0] OP_CRYPTO = 3'b100;
    // Driven on mru_op whenever no operation is being presented to the unit.
    localparam logic [2:0] OP_IDLE   = 3'b111;

    localparam int LAT_W = 4;
    // Minimum cycles the arithmetic unit needs per legal opcode, indexed by opcode.
    localparam logic [LAT_W-1:0] LAT [5] = '{4'd3, 4'd2, 4'd2, 4'd10, 4'd2};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } mru_state_e;

    // Opcodes above crypto are accepted from requesters but never reach the unit.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_CRYPTO);
    endfunction

    // Latency lookup; illegal opcodes return 0 since they are never issued.
    function automatic logic [LAT_W-1:0] lat_of(input logic [2:0] op);
        logic [LAT_W-1:0] lat;
        lat = '0;
        case (op)
            OP_RADIX3: lat = LAT[0];
            OP_RADIX4: lat = LAT[1];
            OP_RADIX6: lat = LAT[2];
            OP_FFT:    lat = LAT[3];
            OP_CRYPTO: lat = LAT[4];
            default:   lat = '0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/mru_rr_arbiter.sv
// mru_rr_arbiter -- combinational round-robin arbiter.
// Searches the request vector starting at the supplied pointer and returns
// the first asserted requester as a one-hot grant plus its index.
module mru_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    int idx;

    // Walk NREQ positions from the pointer, wrapping, and take the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mru_scheduler.sv
// mru_scheduler -- shares one multi-radix arithmetic unit between NREQ
// requesters, one operation outstanding at a time.
// Handshakes: a request transfers on the cycle req_ready[i] pulses (only in
// IDLE, only to the round-robin winner); a response transfers on a cycle
// with rsp_valid && rsp_ready, and rsp_valid/payload hold until then.
// Optional feature: define MRU_SCHED_TIMEOUT_EN to bound WAIT at TIMEOUT
// cycles, after which an error response is returned.
module mru_scheduler
    import mru_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [9*NREQ-1:0] req_a,
    input  logic [9*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [17:0]       rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic [2:0]        mru_op,
    output logic [8:0]        mru_a,
    output logic [8:0]        mru_b,
    input  logic [17:0]       mru_result,
    input  logic              mru_overflow,
    input  logic              mru_ready,
    output mru_state_e        state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    mru_state_e       state_q, state_d;
    logic             run_q;
    logic [PW-1:0]    ptr_q;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [2:0]       sel_op;
    logic [8:0]       sel_a, sel_b;
    logic             accept;
    logic [2:0]       op_q;
    logic [8:0]       a_q, b_q;
    logic [PW-1:0]    id_q;
    logic [LAT_W-1:0] cnt_q;
    logic             wait_done;
    logic             tmo_hit;

    mru_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Operand mux for the current round-robin winner.
    always_comb begin
        sel_op = req_op[3*int'(gnt_idx) +: 3];
        sel_a  = req_a[9*int'(gnt_idx) +: 9];
        sel_b  = req_b[9*int'(gnt_idx) +: 9];
    end

    // run_q keeps req_ready low while reset is asserted even if requests are present.
    assign accept    = run_q && (state_q == ST_IDLE) && gnt_any;
    assign wait_done = (state_q == ST_WAIT) && (cnt_q == '0) && mru_ready;

`ifdef MRU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    // Count cycles spent in WAIT; cleared while the operation is being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            tmo_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle; a normal completion that cycle wins.
    assign tmo_hit = (state_q == ST_WAIT) && (tmo_q == TW'(TIMEOUT - 1)) && !wait_done;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    // Run flag: goes high on the first clock after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_legal(sel_op) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_done || tmo_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grant pulse, response valid and the unit-side command.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        mru_op    = OP_IDLE;
        mru_a     = '0;
        mru_b     = '0;
        if (accept) begin
            req_ready = gnt;
        end
        if (state_q == ST_RESP) begin
            rsp_valid = 1'b1;
        end
        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            mru_op = op_q;
            mru_a  = a_q;
            mru_b  = b_q;
        end
    end

    assign state_dbg = state_q;

    // Datapath: latch the accepted request, run the latency counter, capture the response.
    // The counter loads LAT on acceptance and ISSUE spends the first latency cycle,
    // so WAIT sees LAT-1 .. 0 and the response appears LAT+2 cycles after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            op_q         <= OP_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                id_q  <= gnt_idx;
                cnt_q <= lat_of(sel_op);
                if (!op_legal(sel_op)) begin
                    rsp_id       <= 2'(gnt_idx);
                    rsp_result   <= '0;
                    rsp_overflow <= 1'b0;
                    rsp_err      <= 1'b1;
                end
            end
            if ((state_q == ST_ISSUE || state_q == ST_WAIT) && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (wait_done) begin
                rsp_id       <= 2'(id_q);
                rsp_result   <= mru_result;
                rsp_overflow <= mru_overflow;
                rsp_err      <= 1'b0;
            end else if (tmo_hit) begin
                rsp_id       <= 2'(id_q);
                rsp_result   <= '0;
                rsp_overflow <= 1'b0;
                rsp_err      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mru_scheduler.sv
// tb_mru_scheduler -- directed bench for mru_scheduler with a response scoreboard.
// Builds with or without MRU_SCHED_TIMEOUT_EN; the stuck-unit step adapts.
module tb_mru_scheduler;
    import mru_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [11:0]  req_op;
    logic [35:0]  req_a, req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [17:0]  rsp_result;
    logic         rsp_overflow, rsp_err, rsp_ready;
    logic [2:0]   mru_op;
    logic [8:0]   mru_a, mru_b;
    logic [17:0]  mru_result;
    logic         mru_overflow, mru_ready;
    mru_state_e   state_dbg;

    logic [2:0]   lane_op [4];
    logic [8:0]   lane_a  [4];
    logic [8:0]   lane_b  [4];

    logic [21:0]  exp_q [$];
    int           n_chk  = 0;
    int           n_fail = 0;

    mru_scheduler #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .mru_op(mru_op), .mru_a(mru_a), .mru_b(mru_b),
        .mru_result(mru_result), .mru_overflow(mru_overflow), .mru_ready(mru_ready),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Lane packing
    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < 4; i++) begin
            req_op[3*i +: 3] = lane_op[i];
            req_a[9*i +: 9]  = lane_a[i];
            req_b[9*i +: 9]  = lane_b[i];
        end
    end

    // Arithmetic-unit stand-in
    function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [8:0] a, input logic [8:0] b);
        logic [17:0] p;
        p = 18'(a) * 18'(b);
        return p ^ {15'd0, op};
    endfunction

    assign mru_result   = alu_f(mru_op, mru_a, mru_b);
    assign mru_overflow = mru_a[8] & mru_b[8];

    function automatic logic [21:0] pack(input logic [1:0] id, input logic [17:0] res,
                                         input logic ovf, input logic err);
        return {id, res, ovf, err};
    endfunction

    // Driver / checker tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output logic [3:0] g);
        int n;
        n = 0;
        sample();
        while (req_ready == '0 && n < 40) begin
            sample();
            n++;
        end
        g = req_ready;
        check($sformatf("%s_grant_seen", tag), 32'(req_ready != '0), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int cyc);
        logic [21:0] e;
        cyc = 0;
        while (!rsp_valid && cyc < budget) begin
            sample();
            cyc++;
        end
        check($sformatf("%s_rsp_seen", tag), 32'(rsp_valid), 32'd1);
        if (rsp_valid) begin
            check($sformatf("%s_sb_has_entry", tag), 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s_payload", tag),
                      32'({rsp_id, rsp_result, rsp_overflow, rsp_err}), 32'(e));
            end
        end
    endtask

    // Directed sequence
    initial begin
        logic [3:0]  g;
        logic [21:0] e;
        int          cyc, held, n, lane, seen;

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        mru_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lane_op[i] = OP_IDLE;
            lane_a[i]  = '0;
            lane_b[i]  = '0;
        end

        // Reset values
        repeat (3) step();
        sample();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mru_op", 32'(mru_op), 32'(OP_IDLE));
        check("rst_mru_ab", 32'({mru_a, mru_b}), 32'd0);
        check("rst_payload", 32'({rsp_id, rsp_result, rsp_overflow, rsp_err}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();

        // Single radix4 request on lane 0
        lane_op[0] = OP_RADIX4; lane_a[0] = 9'd5; lane_b[0] = 9'd3;
        req_valid  = 4'b0001;
        exp_q.push_back(pack(2'd0, alu_f(OP_RADIX4, 9'd5, 9'd3), 1'b0, 1'b0));
        sample();
        check("single_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        sample();
        check("single_mru_op", 32'(mru_op), 32'(OP_RADIX4));
        check("single_mru_ab", 32'({mru_a, mru_b}), 32'({9'd5, 9'd3}));
        check("single_ready_pulse", 32'(req_ready), 32'd0);
        wait_rsp("single", 20, cyc);
        check("single_latency", 32'(cyc), 32'd3);
        sample();
        check("single_drain_op", 32'(mru_op), 32'(OP_IDLE));
        check("single_drain_state", 32'(state_dbg), 32'(ST_DRAIN));
        sample();
        check("single_back_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Reset while in WAIT abandons the request
        step();
        lane_op[1] = OP_FFT; lane_a[1] = 9'd7; lane_b[1] = 9'd9;
        req_valid  = 4'b0010;
        sample();
        check("midrst_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();
        sample();
        check("midrst_in_wait", 32'(state_dbg), 32'(ST_WAIT));
        step();
        rst_n = 1'b0;
        sample();
        check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_mru_op", 32'(mru_op), 32'(OP_IDLE));
        check("midrst_mru_ab", 32'({mru_a, mru_b}), 32'd0);
        check("midrst_payload", 32'({rsp_id, rsp_result, rsp_overflow, rsp_err}), 32'd0);
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            sample();
            if (rsp_valid) seen++;
        end
        check("midrst_no_response", 32'(seen), 32'd0);

        // Contention: all lanes fft, grants must rotate 0,1,2,3,0
        step();
        for (int i = 0; i < 4; i++) begin
            lane_op[i] = OP_FFT;
            lane_a[i]  = 9'(10 + 17 * i);
            lane_b[i]  = 9'(20 + 3 * i);
        end
        req_valid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            lane = k % 4;
            wait_grant($sformatf("cont%0d", k), g);
            check($sformatf("cont%0d_order", k), 32'(g), 32'(1 << lane));
            exp_q.push_back(pack(2'(lane), alu_f(OP_FFT, lane_a[lane], lane_b[lane]), 1'b0, 1'b0));
            held = 0;
            n    = 0;
            sample();
            while (!rsp_valid && n < 60) begin
                if (mru_op == OP_FFT && mru_a == lane_a[lane] && mru_b == lane_b[lane]) held++;
                sample();
                n++;
            end
            check($sformatf("cont%0d_op_held", k), 32'(held), 32'd11);
            wait_rsp($sformatf("cont%0d", k), 5, cyc);
        end
        step();
        req_valid = '0;
        sample();
        check("cont_drain", 32'(state_dbg), 32'(ST_DRAIN));
        sample();
        check("cont_idle_no_grant", 32'(req_ready), 32'd0);

        // Backpressure on lane 2 with overflow, plus a request that is cancelled while busy
        step();
        rsp_ready  = 1'b0;
        lane_op[2] = OP_RADIX3; lane_a[2] = 9'd300; lane_b[2] = 9'd260;
        req_valid  = 4'b0100;
        e = pack(2'd2, alu_f(OP_RADIX3, 9'd300, 9'd260), 1'b1, 1'b0);
        exp_q.push_back(e);
        wait_grant("bp", g);
        check("bp_grant", 32'(g), 32'h4);
        step();
        lane_op[1] = OP_CRYPTO;
        req_valid  = 4'b0010;
        sample();
        check("busy_no_ready", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            sample();
            n++;
        end
        check("bp_latency", 32'(n), 32'd4);
        repeat (5) begin
            check("bp_valid_held", 32'(rsp_valid), 32'd1);
            check("bp_payload_held", 32'({rsp_id, rsp_result, rsp_overflow, rsp_err}), 32'(e));
            check("bp_busy_ready", 32'(req_ready), 32'd0);
            sample();
        end
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        sample();
        wait_rsp("bp", 2, cyc);
        sample();
        check("bp_drain_op", 32'(mru_op), 32'(OP_IDLE));
        check("bp_drain_state", 32'(state_dbg), 32'(ST_DRAIN));
        sample();
        check("bp_one_drain", 32'(state_dbg), 32'(ST_IDLE));
        seen = 0;
        repeat (3) begin
            sample();
            if (req_ready != '0 || rsp_valid) seen++;
        end
        check("cancel_silent", 32'(seen), 32'd0);

        // Illegal opcode 110 on lane 3
        step();
        lane_op[3] = 3'b110; lane_a[3] = 9'h1ff; lane_b[3] = 9'h1ff;
        req_valid  = 4'b1000;
        exp_q.push_back(pack(2'd3, 18'd0, 1'b0, 1'b1));
        wait_grant("ill", g);
        check("ill_grant", 32'(g), 32'h8);
        check("ill_op_at_accept", 32'(mru_op), 32'(OP_IDLE));
        step();
        req_valid = '0;
        sample();
        check("ill_direct_resp", 32'(rsp_valid), 32'd1);
        check("ill_op_in_resp", 32'(mru_op), 32'(OP_IDLE));
        wait_rsp("ill", 2, cyc);
        sample();
        check("ill_op_in_drain", 32'(mru_op), 32'(OP_IDLE));
        sample();
        check("ill_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Arithmetic unit never ready
        step();
        mru_ready  = 1'b0;
        lane_op[0] = OP_RADIX6; lane_a[0] = 9'd17; lane_b[0] = 9'd33;
        req_valid  = 4'b0001;
`ifdef MRU_SCHED_TIMEOUT_EN
        exp_q.push_back(pack(2'd0, 18'd0, 1'b0, 1'b1));
`else
        exp_q.push_back(pack(2'd0, alu_f(OP_RADIX6, 9'd17, 9'd33), 1'b0, 1'b0));
`endif
        wait_grant("stuck", g);
        check("stuck_grant", 32'(g), 32'h1);
        step();
        req_valid = '0;
        sample();
`ifdef MRU_SCHED_TIMEOUT_EN
        wait_rsp("timeout", 100, cyc);
        check("timeout_latency", 32'(cyc), 32'd65);
        step();
        mru_ready = 1'b1;
`else
        repeat (100) sample();
        check("stuck_still_wait", 32'(state_dbg), 32'(ST_WAIT));
        check("stuck_no_rsp", 32'(rsp_valid), 32'd0);
        check("stuck_op_held", 32'(mru_op), 32'(OP_RADIX6));
        step();
        mru_ready = 1'b1;
        sample();
        wait_rsp("stuck_release", 3, cyc);
        check("stuck_release_latency", 32'(cyc), 32'd1);
`endif
        repeat (3) sample();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
